memory_arbiter: RTL

Single-port memory arbiter between the instruction cache and the data path/data cache on one side, and the shared RAM on the other. It accepts instruction-fetch requests (iREN/iaddr) and data requests (dREN/dWEN), and grants one at a time to the RAM. It returns the RAM's load word with the matching wait handshake. Data requests take priority, and a bounded starvation counter guarantees forward progress for instruction fetch.

---
 rtl/cpu_types_pkg.sv | 13 +
 rtl/memory_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word, RAM handshake state and the arbiter's
// FSM/grant encodings.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

   typedef enum logic [1:0] {IDLE, ISERV, DSERV} arb_state_t;

   typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} grant_t;

endpackage

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: data requests win, instruction fetch is forced
// through after STARVE_LIMIT-1 back-to-back data completions.
module memory_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic      CLK,
   input  logic      RST,
   input  logic      iREN,
   input  word_t     iaddr,
   output logic      iwait,
   output word_t     iload,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output logic      dwait,
   output word_t     dload,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate,
   output logic      ram_err
);

   localparam int CW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT - 1);

   arb_state_t    state;
   logic [CW-1:0] cnt;
   grant_t        grant;
   logic          d_req;
   logic          done;

   // Grant is the fresh IDLE choice or the locked owner while it keeps asking.
   always_comb begin
      d_req = dREN | dWEN;
      grant = GNT_NONE;
      if (!RST) begin
         unique case (state)
            IDLE: begin
               if (d_req && cnt < CNT_MAX) grant = GNT_D;
               else if (iREN)              grant = GNT_I;
               else if (d_req)             grant = GNT_D;
            end
            ISERV:   if (iREN)  grant = GNT_I;
            DSERV:   if (d_req) grant = GNT_D;
            default: grant = GNT_NONE;
         endcase
      end
      done = (grant != GNT_NONE) && (ramstate == ACCESS);
   end

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      unique case (grant)
         GNT_I: begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (done) begin
               iwait = 1'b0;
               iload = ramload;
            end
         end
         GNT_D: begin
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            if (done) begin
               dwait = 1'b0;
               dload = ramload;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         cnt     <= '0;
         ram_err <= 1'b0;
      end else begin
         if (grant == GNT_NONE || done) state <= IDLE;
         else if (grant == GNT_I)       state <= ISERV;
         else                           state <= DSERV;

         if (!iREN || (done && grant == GNT_I)) cnt <= '0;
         else if (done && grant == GNT_D && cnt < CNT_MAX) cnt <= cnt + CW'(1);

         if (grant != GNT_NONE && ramstate == ERROR) ram_err <= 1'b1;
      end
   end

endmodule
